// File: rtl/mult_test_pkg.sv
// Shared types for the multiply-run sequencer: FSM state encoding and
// the LATENCY upper bound that sizes the drain counter.
package mult_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned LATENCY_MAX = 16;
    localparam int unsigned DRAIN_CW    = $clog2(LATENCY_MAX);

endpackage

// File: rtl/seq_addr_delay.sv
// LATENCY-stage {en, addr} delay line aligning result writes with reads.
// Reset clears every stage; flush drops in-flight enables for a run abort.
module seq_addr_delay #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  en_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic                  en_out,
    output logic [ADDR_WIDTH-1:0] addr_out
);

    logic [LATENCY-1:0]    en_sr;
    logic [ADDR_WIDTH-1:0] addr_sr [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sr <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) addr_sr[i] <= '0;
        end else begin
            en_sr[0]   <= en_in & ~flush;
            addr_sr[0] <= addr_in;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                en_sr[i]   <= en_sr[i-1] & ~flush;
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    assign en_out   = en_sr[LATENCY-1];
    assign addr_out = addr_sr[LATENCY-1];

endmodule

// File: rtl/mult_run_sequencer.sv
// Sequences operand reads 0..N-1, then drains LATENCY cycles of result writes.
// Define MULT_RUN_CYCLE_COUNT_EN to add the saturating cycle_count output.
import mult_test_pkg::*;

module mult_run_sequencer #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  pll_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   num_vectors,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  we,
    output logic                  busy,
    output logic                  done
`ifdef MULT_RUN_CYCLE_COUNT_EN
    ,
    output logic [31:0]           cycle_count
`endif
);

    localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(LATENCY - 1);

    state_t              state, state_next;
    logic [ADDR_WIDTH:0] n_lat;
    logic [DRAIN_CW-1:0] drain_cnt;
    logic                accept;
    logic                last_addr;

    assign accept    = (state == IDLE) && start && !abort;
    // Compare in ADDR_WIDTH+1 bits so N = 2^ADDR_WIDTH ends at all-ones.
    assign last_addr = ({1'b0, r_addr} == (n_lat - 1'b1));

    always_ff @(posedge pll_clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = (num_vectors == '0) ? DONE : RUN;
            RUN:   if (abort) state_next = IDLE;
                   else if (last_addr) state_next = DRAIN;
            DRAIN: if (abort) state_next = IDLE;
                   else if (drain_cnt == DRAIN_LAST) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        r_en = (state == RUN);
        busy = (state != IDLE);
        done = (state == DONE) && !abort;
    end

    always_ff @(posedge pll_clock or posedge reset) begin
        if (reset) begin
            n_lat     <= '0;
            r_addr    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    n_lat <= num_vectors;
                    if (num_vectors != '0) r_addr <= '0;
                end
                RUN: begin
                    drain_cnt <= '0;
                    if (!abort && !last_addr) r_addr <= r_addr + 1'b1;
                end
                DRAIN: drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    seq_addr_delay #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LATENCY   (LATENCY)
    ) u_delay (
        .clk     (pll_clock),
        .rst     (reset),
        .flush   (abort && busy),
        .en_in   (r_en),
        .addr_in (r_addr),
        .en_out  (we),
        .addr_out(w_addr)
    );

`ifdef MULT_RUN_CYCLE_COUNT_EN
    always_ff @(posedge pll_clock or posedge reset) begin
        if (reset)                           cycle_count <= '0;
        else if (accept)                     cycle_count <= '0;
        else if (busy && cycle_count != '1)  cycle_count <= cycle_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mult_run_sequencer.sv
// Randomized self-checking bench for mult_run_sequencer against a
// cycle-indexed reference model derived from the run timing rules.
module tb_mult_run_sequencer;

    localparam int AW = 9;
    localparam int L  = 4;

    logic          pll_clock = 1'b0;
    logic          reset, start, abort;
    logic [AW:0]   num_vectors;
    logic [AW-1:0] r_addr, w_addr;
    logic          r_en, we, busy, done;
`ifdef MULT_RUN_CYCLE_COUNT_EN
    logic [31:0]   cycle_count;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 pll_clock = ~pll_clock;

    mult_run_sequencer #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
        .pll_clock  (pll_clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_vectors(num_vectors),
        .r_addr     (r_addr),
        .r_en       (r_en),
        .w_addr     (w_addr),
        .we         (we),
        .busy       (busy),
        .done       (done)
`ifdef MULT_RUN_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    // Expected {busy, done, r_en, we, r_addr, w_addr} for cycle c of a run of
    // n vectors whose start is in cycle 0; ab = cycle abort is held (-1: none).
    function automatic logic [2*AW+3:0] exp_vec(int c, int n, int ab);
        int dc;
        logic ren, wen, bsy, dn;
        logic [AW-1:0] ra, wa;
        dc = (n == 0) ? 1 : n + L + 1;
        if (ab >= 0 && c > ab) return '0;
        ren = (c >= 1) && (c <= n);
        wen = (c >= L + 1) && (c <= L + n);
        bsy = (c >= 1) && (c <= dc);
        dn  = (c == dc) && (c != ab);
        ra  = ren ? AW'(c - 1) : '0;
        wa  = wen ? AW'(c - 1 - L) : '0;
        return {bsy, dn, ren, wen, ra, wa};
    endfunction

    function automatic logic [2*AW+3:0] obs_vec();
        logic [AW-1:0] ra, wa;
        ra = r_en ? r_addr : '0;
        wa = we ? w_addr : '0;
        return {busy, done, r_en, we, ra, wa};
    endfunction

    task automatic drive_cycle(input logic s, input logic a, input logic [AW:0] nv);
        @(negedge pll_clock);
        start       = s;
        abort       = a;
        num_vectors = nv;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_vectors = '0;
        #12;
        checks++;
        if (obs_vec() !== '0 || r_addr !== '0 || w_addr !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %h/%h/%h required 0", obs_vec(), r_addr, w_addr);
        end
`ifdef MULT_RUN_CYCLE_COUNT_EN
        checks++;
        if (cycle_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_cycle_count got %0d required 0", cycle_count);
        end
`endif
        @(negedge pll_clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        for (int c = 0; c <= 5 + L + 3; c++) begin
            drive_cycle(c == 0, 1'b0, (AW+1)'(5));
            checks++;
            if (obs_vec() !== exp_vec(c, 5, -1)) begin
                fails++;
                $display("FAIL basic c=%0d got %h required %h", c, obs_vec(), exp_vec(c, 5, -1));
            end
        end
        checks++;
        if (r_addr !== AW'(4)) begin
            fails++;
            $display("FAIL basic_raddr_hold got %0d required 4", r_addr);
        end
    endtask

    task automatic test_zero();
        for (int c = 0; c <= 4; c++) begin
            drive_cycle(c == 0, 1'b0, '0);
            checks++;
            if (obs_vec() !== exp_vec(c, 0, -1)) begin
                fails++;
                $display("FAIL zero c=%0d got %h required %h", c, obs_vec(), exp_vec(c, 0, -1));
            end
        end
    endtask

    task automatic test_full();
        int n_rd = 0;
        int n_wr = 0;
        for (int c = 0; c <= 512 + L + 3; c++) begin
            drive_cycle(c == 0, 1'b0, (AW+1)'(512));
            n_rd += int'(r_en);
            n_wr += int'(we);
            checks++;
            if (obs_vec() !== exp_vec(c, 512, -1)) begin
                fails++;
                $display("FAIL full c=%0d got %h required %h", c, obs_vec(), exp_vec(c, 512, -1));
            end
        end
        checks++;
        if (n_rd != 512 || n_wr != 512 || r_addr !== AW'(511)) begin
            fails++;
            $display("FAIL full_counts got rd=%0d wr=%0d last=%0d required 512/512/511", n_rd, n_wr, r_addr);
        end
    endtask

    task automatic test_abort();
        int n_wr = 0;
        for (int c = 0; c <= 8 + L + 3; c++) begin
            drive_cycle(c == 0, c == 3, (AW+1)'(8));
            n_wr += int'(we);
            checks++;
            if (obs_vec() !== exp_vec(c, 8, 3)) begin
                fails++;
                $display("FAIL abort c=%0d got %h required %h", c, obs_vec(), exp_vec(c, 8, 3));
            end
        end
        checks++;
        if (n_wr > 2 || r_addr !== AW'(2)) begin
            fails++;
            $display("FAIL abort_tail got we=%0d raddr=%0d required <=2 and 2", n_wr, r_addr);
        end
    endtask

    task automatic test_start_abort();
        for (int c = 0; c <= 4; c++) begin
            drive_cycle(c == 0, c == 0, (AW+1)'(7));
            checks++;
            if (obs_vec() !== '0) begin
                fails++;
                $display("FAIL start_abort c=%0d got %h required 0", c, obs_vec());
            end
        end
    endtask

    task automatic test_ignore();
        int n_done = 0;
        for (int c = 0; c <= 6 + L + 3; c++) begin
            drive_cycle(c == 0 || c == 2 || c == 4, 1'b0, (c < 2) ? (AW+1)'(6) : (AW+1)'(3));
            n_done += int'(done);
            checks++;
            if (obs_vec() !== exp_vec(c, 6, -1)) begin
                fails++;
                $display("FAIL ignore c=%0d got %h required %h", c, obs_vec(), exp_vec(c, 6, -1));
            end
        end
        checks++;
        if (n_done != 1) begin
            fails++;
            $display("FAIL ignore_done got %0d required 1", n_done);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int n, ab, dc, lim;
            n  = $urandom_range(0, 40);
            dc = (n == 0) ? 1 : n + L + 1;
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, dc)) : -1;
            lim = (ab >= 0) ? ab : dc;
            for (int c = 0; c <= dc + 2; c++) begin
                logic s;
                s = (c == 0) || (c <= lim && $urandom_range(0, 3) == 0);
                drive_cycle(s, c == ab, (c == 0) ? (AW+1)'(n) : (AW+1)'($urandom_range(0, 512)));
                checks++;
                if (obs_vec() !== exp_vec(c, n, ab)) begin
                    fails++;
                    $display("FAIL random r=%0d n=%0d ab=%0d c=%0d got %h required %h",
                             r, n, ab, c, obs_vec(), exp_vec(c, n, ab));
                end
            end
        end
    endtask

    task automatic test_reset_drain();
        int n_wr = 0;
        for (int c = 0; c <= 6; c++) drive_cycle(c == 0, 1'b0, (AW+1)'(4));
        reset = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== '0 || r_addr !== '0 || w_addr !== '0) begin
            fails++;
            $display("FAIL reset_drain got %h/%h/%h required 0", obs_vec(), r_addr, w_addr);
        end
        @(negedge pll_clock);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0, 1'b0, (AW+1)'(4));
            n_wr += int'(we) + int'(busy);
        end
        checks++;
        if (n_wr != 0) begin
            fails++;
            $display("FAIL reset_drain_quiet got %0d we/busy cycles required 0", n_wr);
        end
`ifdef MULT_RUN_CYCLE_COUNT_EN
        for (int c = 0; c <= 4 + L + 3; c++) drive_cycle(c == 0, 1'b0, (AW+1)'(4));
        checks++;
        if (cycle_count !== 32'd9) begin
            fails++;
            $display("FAIL cycle_count got %0d required 9", cycle_count);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_full();
        test_abort();
        test_start_abort();
        test_ignore();
        test_random();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
